// File: rtl/exc_commit_seq.sv
// Exception / ERET commit sequencer: freeze, drain the bus, update CP0, flush, redirect.
module exc_commit_seq #(
    parameter int unsigned DRAIN_MAX    = 16,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delay_slot,
    input  logic [31:0] exc_badvaddr,
    input  logic [31:0] exc_location,
    input  logic [1:0]  exc_ce,
    input  logic        is_eret,
    input  logic [31:0] cp0_epc,
    input  logic        mem_busy,
    output logic        stall_req,
    output logic        cp0_exc_we,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_bd_o,
    output logic [4:0]  cp0_code_o,
    output logic [1:0]  cp0_ce_o,
    output logic        cp0_badvaddr_we,
    output logic [31:0] cp0_badvaddr_o,
    output logic        cp0_exl_set,
    output logic        cp0_exl_clr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        drain_timeout,
    output logic        busy
);

    localparam int unsigned DCW = 5;
    localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_COMMIT = 2'd2,
        S_FLUSH  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    logic [FCW-1:0]  fcnt_q, fcnt_d;

    // captured record
    logic            eret_q, eret_d;
    logic [31:0]     epc_q, epc_d;
    logic            bd_q, bd_d;
    logic [4:0]      code_q, code_d;
    logic [1:0]      ce_q, ce_d;
    logic [31:0]     bva_q, bva_d;
    logic [31:0]     target_q, target_d;

    // registered outputs
    logic            stall_q, stall_d;
    logic            exc_we_q, exc_we_d;
    logic [31:0]     epc_o_q, epc_o_d;
    logic            bd_o_q, bd_o_d;
    logic [4:0]      code_o_q, code_o_d;
    logic [1:0]      ce_o_q, ce_o_d;
    logic            bva_we_q, bva_we_d;
    logic [31:0]     bva_o_q, bva_o_d;
    logic            exl_set_q, exl_set_d;
    logic            exl_clr_q, exl_clr_d;
    logic            flush_q, flush_d;
    logic            rdr_valid_q, rdr_valid_d;
    logic [31:0]     rdr_pc_q, rdr_pc_d;
    logic            timeout_q, timeout_d;
    logic            busy_q, busy_d;

    logic            drain_last;
    logic            code_has_bva;

    assign drain_last   = (dcnt_q == DCW'(DRAIN_MAX - 1));
    assign code_has_bva = (code_q >= 5'd1) && (code_q <= 5'd5);

    // Next state, capture and next-cycle output values
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        fcnt_d      = fcnt_q;
        eret_d      = eret_q;
        epc_d       = epc_q;
        bd_d        = bd_q;
        code_d      = code_q;
        ce_d        = ce_q;
        bva_d       = bva_q;
        target_d    = target_q;
        exc_we_d    = 1'b0;
        epc_o_d     = 32'd0;
        bd_o_d      = 1'b0;
        code_o_d    = 5'd0;
        ce_o_d      = 2'd0;
        bva_we_d    = 1'b0;
        bva_o_d     = 32'd0;
        exl_set_d   = 1'b0;
        exl_clr_d   = 1'b0;
        flush_d     = 1'b0;
        rdr_valid_d = 1'b0;
        rdr_pc_d    = 32'd0;
        timeout_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (exc_valid) begin
                    eret_d   = 1'b0;
                    epc_d    = exc_in_delay_slot ? (exc_pc - 32'd4) : exc_pc;
                    bd_d     = exc_in_delay_slot;
                    code_d   = exc_code;
                    ce_d     = exc_ce;
                    bva_d    = exc_badvaddr;
                    target_d = exc_location;
                    dcnt_d   = '0;
                    state_d  = S_DRAIN;
                end else if (is_eret) begin
                    eret_d   = 1'b1;
                    epc_d    = 32'd0;
                    bd_d     = 1'b0;
                    code_d   = 5'd0;
                    ce_d     = 2'd0;
                    bva_d    = 32'd0;
                    target_d = cp0_epc;
                    dcnt_d   = '0;
                    state_d  = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!mem_busy || drain_last) begin
                    state_d   = S_COMMIT;
                    timeout_d = mem_busy;
                    if (!eret_q) begin
                        exc_we_d  = 1'b1;
                        exl_set_d = 1'b1;
                        epc_o_d   = epc_q;
                        bd_o_d    = bd_q;
                        code_o_d  = code_q;
                        ce_o_d    = ce_q;
                        if (code_has_bva) begin
                            bva_we_d = 1'b1;
                            bva_o_d  = bva_q;
                        end
                    end else begin
                        exl_clr_d = 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q + DCW'(1);
                end
            end
            S_COMMIT: begin
                state_d     = S_FLUSH;
                fcnt_d      = '0;
                flush_d     = 1'b1;
                rdr_valid_d = 1'b1;
                rdr_pc_d    = target_q;
            end
            S_FLUSH: begin
                if (fcnt_q == FCW'(FLUSH_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    fcnt_d   = fcnt_q + FCW'(1);
                    flush_d  = 1'b1;
                    rdr_pc_d = rdr_pc_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        stall_d = (state_d != S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State, captured record and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dcnt_q      <= '0;
            fcnt_q      <= '0;
            eret_q      <= 1'b0;
            epc_q       <= 32'd0;
            bd_q        <= 1'b0;
            code_q      <= 5'd0;
            ce_q        <= 2'd0;
            bva_q       <= 32'd0;
            target_q    <= 32'd0;
            stall_q     <= 1'b0;
            exc_we_q    <= 1'b0;
            epc_o_q     <= 32'd0;
            bd_o_q      <= 1'b0;
            code_o_q    <= 5'd0;
            ce_o_q      <= 2'd0;
            bva_we_q    <= 1'b0;
            bva_o_q     <= 32'd0;
            exl_set_q   <= 1'b0;
            exl_clr_q   <= 1'b0;
            flush_q     <= 1'b0;
            rdr_valid_q <= 1'b0;
            rdr_pc_q    <= 32'd0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            fcnt_q      <= fcnt_d;
            eret_q      <= eret_d;
            epc_q       <= epc_d;
            bd_q        <= bd_d;
            code_q      <= code_d;
            ce_q        <= ce_d;
            bva_q       <= bva_d;
            target_q    <= target_d;
            stall_q     <= stall_d;
            exc_we_q    <= exc_we_d;
            epc_o_q     <= epc_o_d;
            bd_o_q      <= bd_o_d;
            code_o_q    <= code_o_d;
            ce_o_q      <= ce_o_d;
            bva_we_q    <= bva_we_d;
            bva_o_q     <= bva_o_d;
            exl_set_q   <= exl_set_d;
            exl_clr_q   <= exl_clr_d;
            flush_q     <= flush_d;
            rdr_valid_q <= rdr_valid_d;
            rdr_pc_q    <= rdr_pc_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign stall_req       = stall_q;
    assign cp0_exc_we      = exc_we_q;
    assign cp0_epc_o       = epc_o_q;
    assign cp0_bd_o        = bd_o_q;
    assign cp0_code_o      = code_o_q;
    assign cp0_ce_o        = ce_o_q;
    assign cp0_badvaddr_we = bva_we_q;
    assign cp0_badvaddr_o  = bva_o_q;
    assign cp0_exl_set     = exl_set_q;
    assign cp0_exl_clr     = exl_clr_q;
    assign flush           = flush_q;
    assign redirect_valid  = rdr_valid_q;
    assign redirect_pc     = rdr_pc_q;
    assign drain_timeout   = timeout_q;
    assign busy            = busy_q;

endmodule
